// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared constants for the instruction fetch stage and the
//               program counter: default widths, reset PC and the NOP
//               encoding placed in the IF/ID register when it is flushed.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam int unsigned C_ADDR_WIDTH  = 10;
    localparam int unsigned C_DATA_WIDTH  = 32;
    localparam int unsigned C_COUNT_WIDTH = 16;
    localparam int unsigned C_RESET_PC    = 0;

    // addi x0, x0, 0 -- architectural no-op
    localparam logic [31:0] C_NOP = 32'h0000_0013;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Word-address program counter with load (highest priority)
//               and increment. Arithmetic wraps modulo 2^ADDR_WIDTH.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset (pc = RESET_PC)
//               load       - load load_value into pc
//               load_value - new pc value
//               inc        - advance pc by one word when not loading
//               pc         - current program counter (register output)
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int unsigned RESET_PC   = C_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (inc) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= ADDR_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : program_counter
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Requester side of the instruction memory interface. Holds
//               the PC, drives the word address to a combinational memory,
//               registers the returned instruction into the IF/ID register
//               and hands it to decode with a valid/ready handshake.
//               Supports back-pressure stalls, redirects and fetch enable.
// Ports       : clk             - clock, rising edge
//               reset           - asynchronous active-high reset
//               fetch_enable    - allow new fetches to be captured
//               redirect        - one-cycle PC jump request
//               redirect_target - new word address for a redirect
//               address         - word address to memory (PC register)
//               instruction     - combinational memory read data
//               if_valid        - IF/ID register holds a valid instruction
//               if_ready        - decode accepts IF/ID contents this cycle
//               if_instruction  - registered instruction
//               if_pc           - word address of the registered instruction
//               fetch_count     - completed handshakes, wraps at 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned RESET_PC   = C_RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_enable,
    input  logic                     redirect,
    input  logic [ADDR_WIDTH-1:0]    redirect_target,
    output logic [ADDR_WIDTH-1:0]    address,
    input  logic [DATA_WIDTH-1:0]    instruction,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [DATA_WIDTH-1:0]    if_instruction,
    output logic [ADDR_WIDTH-1:0]    if_pc,
    output logic [C_COUNT_WIDTH-1:0] fetch_count
);

    localparam logic [DATA_WIDTH-1:0] C_NOP_W = DATA_WIDTH'(C_NOP);

    logic [ADDR_WIDTH-1:0]    pc;

    logic                     if_valid_q;
    logic                     if_valid_d;
    logic [DATA_WIDTH-1:0]    if_instruction_q;
    logic [DATA_WIDTH-1:0]    if_instruction_d;
    logic [ADDR_WIDTH-1:0]    if_pc_q;
    logic [ADDR_WIDTH-1:0]    if_pc_d;
    logic [C_COUNT_WIDTH-1:0] fetch_count_q;
    logic [C_COUNT_WIDTH-1:0] fetch_count_d;

    logic                     w_cap;
    logic                     w_handshake;

    // Capture when enabled and the IF/ID slot is empty or being drained.
    assign w_cap       = fetch_enable & (~if_valid_q | if_ready);
    assign w_handshake = if_valid_q & if_ready;

    // Redirect overrides capture, so the PC only advances on an
    // un-redirected capture.
    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_program_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (redirect),
        .load_value (redirect_target),
        .inc        (w_cap & ~redirect),
        .pc         (pc)
    );

    always_comb begin
        if_valid_d       = if_valid_q;
        if_instruction_d = if_instruction_q;
        if_pc_d          = if_pc_q;
        fetch_count_d    = fetch_count_q;

        // A handshake completing on a redirect edge still counts.
        if (w_handshake) begin
            fetch_count_d = fetch_count_q + C_COUNT_WIDTH'(1);
        end

        if (redirect) begin
            // Flush: the word at the old PC and any stalled entry are dropped.
            if_valid_d       = 1'b0;
            if_instruction_d = C_NOP_W;
        end else if (w_cap) begin
            if_valid_d       = 1'b1;
            if_instruction_d = instruction;
            if_pc_d          = pc;
        end else if (w_handshake) begin
            // Fetch disabled: the slot empties once decode takes it.
            if_valid_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid_q       <= 1'b0;
            if_instruction_q <= C_NOP_W;
            if_pc_q          <= '0;
            fetch_count_q    <= '0;
        end else begin
            if_valid_q       <= if_valid_d;
            if_instruction_q <= if_instruction_d;
            if_pc_q          <= if_pc_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign address        = pc;
    assign if_valid       = if_valid_q;
    assign if_instruction = if_instruction_q;
    assign if_pc          = if_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A behavioural
//               model of the fetch stage (expected PC, IF/ID slot and
//               delivered count) is advanced once per clock from the same
//               inputs and compared against the DUT after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          reset;
    logic          fetch_enable;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] address;
    logic [DW-1:0] instruction;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instruction;
    logic [AW-1:0] if_pc;
    logic [15:0]   fetch_count;

    logic [DW-1:0] mem [DEPTH];

    // Reference model state
    int unsigned   m_pc;
    bit            m_valid;
    logic [31:0]   m_instr;
    int unsigned   m_ipc;
    int unsigned   m_count;

    int            n_vec;
    int            n_err;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_enable    (fetch_enable),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .address         (address),
        .instruction     (instruction),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .fetch_count     (fetch_count)
    );

    // Combinational instruction memory
    assign instruction = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_valid = 1'b0;
        m_instr = NOP;
        m_ipc   = 0;
        m_count = 0;
    endtask

    // One clock edge of the fetch stage, straight from the priority rules.
    task automatic model_edge(input bit fe, input bit rdy, input bit rd, input int unsigned tgt);
        bit take;
        take = fe && (!m_valid || rdy);
        if (m_valid && rdy) m_count = (m_count + 1) % 65536;
        if (rd) begin
            m_pc    = tgt % DEPTH;
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (take) begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % DEPTH;
        end else if (!fe && rdy && m_valid) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".address"},  32'(address),        32'(m_pc));
        chk({tag, ".valid"},    32'(if_valid),       32'(m_valid));
        chk({tag, ".instr"},    if_instruction,      m_instr);
        chk({tag, ".if_pc"},    32'(if_pc),          32'(m_ipc));
        chk({tag, ".count"},    32'(fetch_count),    32'(m_count));
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, compare.
    task automatic step(input string tag, input bit fe, input bit rdy,
                        input bit rd, input int unsigned tgt);
        fetch_enable    = fe;
        if_ready        = rdy;
        redirect        = rd;
        redirect_target = AW'(tgt);
        model_edge(fe, rdy, rd, tgt);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        reset           = 1'b1;
        fetch_enable    = 1'b0;
        if_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        model_reset();
        #1;
        check_all("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_all("reset_hold");
        reset = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 8; i++) step("seq", 1, 1, 0, 0);
        // Stall for three cycles, then release
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0);
        step("stall_rel", 1, 1, 0, 0);
        step("stream", 1, 1, 0, 0);
        // Redirect back to word 2
        step("redir", 1, 1, 1, 2);
        step("redir_f1", 1, 1, 0, 0);
        step("redir_f2", 1, 1, 0, 0);
        // Redirect while stalled
        step("rs_stall", 1, 0, 0, 0);
        step("rs_stall", 1, 0, 0, 0);
        step("rs_redir", 1, 0, 1, 0);
        step("rs_after", 1, 1, 0, 0);
        step("rs_after", 1, 1, 0, 0);
        // PC wrap at the top of the address space
        step("wrap_redir", 1, 1, 1, DEPTH - 1);
        for (int i = 0; i < 3; i++) step("wrap", 1, 1, 0, 0);
        // Fetch disable drains the slot and freezes the address
        for (int i = 0; i < 3; i++) step("disable", 0, 1, 0, 0);
        step("disable_stall", 0, 0, 0, 0);
        step("reenable", 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 5),
                 $urandom_range(0, DEPTH - 1));
        end

        // Asynchronous reset between edges while streaming
        step("pre_rst", 1, 1, 0, 0);
        step("pre_rst", 1, 1, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.address", 32'(address),     32'd0);
        chk("arst.valid",   32'(if_valid),    32'd0);
        chk("arst.count",   32'(fetch_count), 32'd0);
        chk("arst.instr",   if_instruction,   NOP);
        model_reset();
        @(negedge clk);
        check_all("arst_hold");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step("post_rst", 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Requester side of the instruction memory interface.
- Holds the program counter and drives the word address to the combinational instruction_memory.
- Registers the returned 32-bit instruction into an IF/ID output register, presented to decode with a valid/ready handshake.
- Supports stall via back-pressure, redirect for branches and jumps, and a fetch enable; sits between instruction_memory and the decode stage.

Parameters:
- ADDR_WIDTH, 10, word-address width; matches the instruction_memory address port.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, word address loaded into the PC on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_enable  input  1  when high, new fetches may be captured.
- redirect  input  1  one-cycle request to jump the PC.
- redirect_target  input  ADDR_WIDTH  new word address, sampled when redirect=1.
- address  output  ADDR_WIDTH  word address to instruction_memory; equals the PC register.
- instruction  input  DATA_WIDTH  combinational data from instruction_memory for the current address.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_ready  input  1  decode accepts the IF/ID contents this cycle.
- if_instruction  output  DATA_WIDTH  registered instruction.
- if_pc  output  ADDR_WIDTH  word address the registered instruction came from.
- fetch_count  output  16  number of instructions delivered (handshakes completed); wraps at 2^16.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, address=RESET_PC, if_valid=0, if_instruction=NOP (0x00000013), if_pc=0, fetch_count=0.
- On reset deassertion, the first capture happens on the first clk edge with fetch_enable=1.
- address is the PC register output only; no combinational path from any input.
- Capture condition: cap = fetch_enable & (~if_valid | if_ready).
- Handshake: a transfer completes on an edge where if_valid=1 and if_ready=1; fetch_count increments by 1 on that edge.
- Edge priority, highest first:
  1. redirect=1: pc <= redirect_target; if_valid <= 0; if_instruction <= NOP. The fetched instruction at the old pc is discarded. A handshake completing on the same edge still counts in fetch_count.
  2. cap=1: if_instruction <= instruction; if_pc <= pc; if_valid <= 1; pc <= pc+1.
  3. fetch_enable=0 and if_ready=1 with if_valid=1: if_valid <= 0; pc unchanged.
  4. Otherwise hold all state. This is a stall: if_valid=1, if_ready=0, and if_instruction/if_pc stay stable.
- Latency: the instruction at address N appears on if_instruction one edge after pc=N with cap=1.
- Throughput: 1 instruction/cycle while if_ready=1.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc=1023 increments to 0 with no flag.
- redirect_target wraps naturally; any value is legal.
- Redirect during stall: the stalled if_instruction is dropped and if_valid=0 the next cycle. Decode must not assume a stalled instruction persists across redirect.
- Reset mid-stall or mid-redirect: reset wins asynchronously; all state returns to reset values.
- fetch_count wraps 0xFFFF -> 0x0000.

Decomposition:
- Shared package (fetch_pkg or a header include):
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - RESET_PC.
  - NOP encoding 32'h00000013.
  - fetch_count width of 16.
- One natural sub-module, program_counter:
  - Inputs: clk, reset, load, load_value, inc.
  - Output: pc.
  - Reused later by the branch unit.
  - IF/ID register and counter logic stay in instruction_fetch.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then fetch_enable=1, if_ready=1, memory preloaded with words W0..W7.
  - Response: address steps 0,1,2,…,7 one per cycle; if_instruction=W0 with if_pc=0 one edge after reset release, then W1..W7 each cycle; fetch_count=8 after eight handshakes.
- Stall:
  - Stimulus: during streaming, if_ready=0 for 3 cycles while if_pc=3.
  - Response: if_instruction=W3, if_pc=3, if_valid=1 held for 3 cycles; address stays 4; on if_ready=1, W4 follows next cycle; no count increment during stall.
- Redirect:
  - Stimulus: at pc=5, redirect=1 with redirect_target=2.
  - Response: next cycle if_valid=0, if_instruction=0x00000013, address=2; following cycle if_instruction=W2, if_pc=2.
- Redirect during stall:
  - Stimulus: if_valid=1, if_ready=0 holding W6; redirect=1 with target=0.
  - Response: W6 dropped; if_valid=0 next cycle; fetch_count unchanged; W0 delivered after.
- Wrap and enable:
  - Stimulus: redirect_target=1023, fetch_enable=1.
  - Response: if_pc sequence is 1023 then 0.
  - Stimulus: then fetch_enable=0 with if_ready=1.
  - Response: if_valid drops after one handshake; address frozen.
- Async reset:
  - Stimulus: assert reset mid-cycle between edges while streaming.
  - Response: if_valid=0, address=0, fetch_count=0 immediately, without waiting for clk.
